// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// The fetch unit takes the master view; memory/decode/branch logic the slave view.
interface fetch_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_dout;
   logic                  redirect;
   logic [DATA_WIDTH-1:0] redirect_target;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr;
   logic [DATA_WIDTH-1:0] instr_pc;
   logic [DATA_WIDTH-1:0] instr_pc4;

   modport master (
      output imem_addr,
      input  imem_dout,
      input  redirect,
      input  redirect_target,
      output instr_valid,
      input  instr_ready,
      output instr,
      output instr_pc,
      output instr_pc4
   );

   modport slave (
      input  imem_addr,
      output imem_dout,
      output redirect,
      output redirect_target,
      input  instr_valid,
      output instr_ready,
      input  instr,
      input  instr_pc,
      input  instr_pc4
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per cycle into a
// 2-entry FIFO handed to decode over valid/ready; redirects flush and restart.
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] fifoInstr_q [2];
   logic [DATA_WIDTH-1:0] fifoPc_q    [2];
   logic                  rdPtr_q, rdPtr_d;
   logic                  wrPtr_q, wrPtr_d;
   logic [1:0]            count_q, count_d;
   logic                  pop;
   logic                  enq;

   // Enqueue is allowed on a full FIFO when the head leaves this cycle,
   // which keeps the stream bubble-free once decode resumes.
   assign pop = (count_q != 2'd0) & bus.instr_ready;
   assign enq = ~bus.redirect & ((count_q < 2'd2) | pop);

   always_comb begin
      pc_d    = pc_q;
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (bus.redirect) begin
         pc_d    = {bus.redirect_target[DATA_WIDTH-1:2], 2'b00};
         rdPtr_d = 1'b0;
         wrPtr_d = 1'b0;
         count_d = 2'd0;
      end else begin
         if (enq) begin
            pc_d    = pc_q + DATA_WIDTH'(4);
            wrPtr_d = ~wrPtr_q;
         end
         if (pop) begin
            rdPtr_d = ~rdPtr_q;
         end
         count_d = count_q + {1'b0, enq} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         rdPtr_q <= 1'b0;
         wrPtr_q <= 1'b0;
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifoInstr_q[i] <= '0;
            fifoPc_q[i]    <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
         if (enq) begin
            fifoInstr_q[wrPtr_q] <= bus.imem_dout;
            fifoPc_q[wrPtr_q]    <= pc_q;
         end
      end
   end

   // With an empty FIFO the head slot still shows its last contents.
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = (count_q != 2'd0);
   assign bus.instr       = fifoInstr_q[rdPtr_q];
   assign bus.instr_pc    = fifoPc_q[rdPtr_q];
   assign bus.instr_pc4   = fifoPc_q[rdPtr_q] + DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based model predicts the fetched
// stream and a negedge monitor compares DUT outputs against it.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   entry_t expQ [$];
   logic [31:0] pcModel = RESET_PC;
   int     rstEpoch  = 0;
   int     seenEpoch = 0;
   int     checks    = 0;
   int     passes    = 0;

   fetch_unit_if #(.DATA_WIDTH(32)) bus ();

   fetch_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory word at byte address a holds its word index.
   function automatic logic [31:0] memFn(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   assign bus.imem_dout = memFn(bus.imem_addr);

   // Reference model: a bounded queue of fetched words; fetch whenever the
   // queue has room once this cycle's accepted head has been removed.
   always @(posedge clk) begin
      if (rst) begin
         expQ.delete();
         pcModel  <= RESET_PC;
         rstEpoch <= rstEpoch + 1;
      end else if (bus.redirect) begin
         expQ.delete();
         pcModel <= bus.redirect_target & 32'hFFFF_FFFC;
      end else if (expQ.size() < 2) begin
         expQ.push_back('{pc: pcModel, ins: memFn(pcModel)});
         pcModel <= pcModel + 32'd4;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rstEpoch != 0) begin
         checkOutput("imem_addr", bus.imem_addr, pcModel);
         checkOutput("instr_valid", 32'(bus.instr_valid), 32'(expQ.size() != 0));
         if (rstEpoch != seenEpoch) begin
            seenEpoch = rstEpoch;
            checkOutput("reset_instr", bus.instr, 32'h0);
            checkOutput("reset_instr_pc", bus.instr_pc, 32'h0);
            checkOutput("reset_instr_pc4", bus.instr_pc4, 32'h4);
         end
         if (expQ.size() != 0) begin
            checkOutput("instr", bus.instr, expQ[0].ins);
            checkOutput("instr_pc", bus.instr_pc, expQ[0].pc);
            checkOutput("instr_pc4", bus.instr_pc4, expQ[0].pc + 32'd4);
            if (bus.instr_ready) begin
               void'(expQ.pop_front());
            end
         end
      end
   end

   task automatic applyStimulus(input logic rstV, input logic redirV,
                                input logic [31:0] tgt, input logic rdy, input int n);
      rst                 = rstV;
      bus.redirect        = redirV;
      bus.redirect_target = tgt;
      bus.instr_ready     = rdy;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.redirect        = 1'b0;
      bus.redirect_target = 32'h0;
      bus.instr_ready     = 1'b0;

      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 8);

      // Stall decode then release: stream must resume without gaps.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 3);
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4);

      applyStimulus(1'b0, 1'b1, 32'h43, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);

      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4);

      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(99) == 0),
                       ($urandom_range(11) == 0),
                       $urandom,
                       ($urandom_range(3) != 0),
                       1);
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the decode/control stage (instruction memory, control unit, sign extender). Owns the program counter, drives the instruction-memory address, and buffers fetched instructions in a 2-entry FIFO presented to decode over a valid/ready handshake. Accepts a redirect (taken branch/jump, i.e. PCsrc with computed target) that flushes in-flight instructions and restarts fetch at the target.

## Interface

- DATA_WIDTH, 32, width of PC, target and instruction words
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  DATA_WIDTH  fetch address to instruction memory (equals internal PC register)
- imem_dout  in  DATA_WIDTH  instruction word; combinational read of imem_addr, valid same cycle
- redirect  in  1  taken branch/jump this cycle
- redirect_target  in  DATA_WIDTH  new PC when redirect=1 (bits [1:0] ignored, treated as 0)
- instr_valid  out  1  FIFO head holds a valid instruction
- instr_ready  in  1  decode accepts head this cycle
- instr  out  DATA_WIDTH  instruction at FIFO head
- instr_pc  out  DATA_WIDTH  PC of instruction at FIFO head
- instr_pc4  out  DATA_WIDTH  instr_pc + 4 (mod 2^DATA_WIDTH)

## Operation

- State: pc_q (DATA_WIDTH), 2-entry FIFO of {instr, pc}, rd_ptr/wr_ptr (1 bit each), count (0..2).
- imem_addr = pc_q always.
- pop = instr_valid & instr_ready.
- enq = !redirect & (count < 2 | pop). When enq: write {imem_dout, pc_q} at wr_ptr, pc_q <= pc_q + 4.
- No enq (FIFO full, no pop): pc_q holds; same address refetched next cycle.
- count update: count + enq − pop (no redirect).
- Redirect (highest priority, overrides pop and enq): count <= 0, pointers <= 0, pc_q <= {redirect_target[DATA_WIDTH-1:2], 2'b00}. Any pop handshake in the redirect cycle is still considered consumed by decode, but FIFO is cleared regardless. No instruction is enqueued in the redirect cycle.
- instr_valid = (count != 0). instr, instr_pc, instr_pc4 driven from FIFO head; when count==0 they hold the last-written head entry contents (don't-care for decode, but deterministic).
- PC arithmetic: unsigned modulo 2^DATA_WIDTH; pc_q = 32'hFFFF_FFFC wraps to 0 with no flag.
- Order preserved: instructions leave in fetch order; no duplicates, no drops except on redirect flush.

## Timing

- Reset (rst=1 at edge): pc_q=RESET_PC, count=0, pointers=0, FIFO storage cleared to 0; outputs: imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_pc4=4.
- Reset dominates redirect and handshake; reset mid-stream discards FIFO contents.
- First edge after rst deasserts: instruction at RESET_PC enqueued; instr_valid=1 from the following cycle (fetch-to-valid latency 1 cycle).
- Throughput: 1 instruction/cycle sustained with instr_ready held high (count steady at 1).
- instr_ready low: FIFO fills in 2 cycles, then pc_q stalls; resuming ready gives one pop per cycle with no bubble (enq allowed on full+pop).
- Redirect at edge N: instr_valid=0 in cycle N+1, imem_addr=target in cycle N+1, target instruction valid at head in cycle N+2 (redirect penalty: 1 bubble).
- Back-to-back redirects: each restarts; only the last target is fetched.
- instr_valid never depends combinationally on instr_ready; all outputs except imem_addr-to-memory path are registered.

## Test plan

- Reset then instr_ready=1, memory word[i]=i: instr_valid rises 1 cycle after reset release; instr_pc sequence 0,4,8,12…, instr = 0,1,2,3…, instr_pc4 = instr_pc+4.
- Hold instr_ready=0 for 5 cycles after first valid: count saturates at 2, imem_addr freezes at 8; release ready: pops pc 0,4,8,12 on consecutive cycles, no gap, no duplicate.
- Redirect=1, redirect_target=32'h40 while FIFO holds 2 entries: next cycle instr_valid=0, imem_addr=32'h40; cycle after, instr_pc=32'h40, old entries never appear.
- Redirect with redirect_target=32'h43 simultaneous with pop: pc_q=32'h40, FIFO empty next cycle.
- Preload pc via redirect to 32'hFFFF_FFFC: fetched pc sequence FFFF_FFFC, 0000_0000; instr_pc4 for first = 0.
- Assert rst mid-stream with count=2 and redirect=1: next cycle instr_valid=0, imem_addr=RESET_PC, instr=0.
